// File: rtl/ring_monitor_pkg.sv
// Shared types and helpers for the ring rotation monitor.
package ring_monitor_pkg;

  localparam int unsigned WIDTH_DEFAULT = 5;
  localparam int unsigned ROT_MAX_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  // One-step rotation of the low w bits of x: bit w-1 wraps into bit 0.
  // Works up to ROT_MAX_W; callers truncate the result to their width.
  function automatic logic [ROT_MAX_W-1:0] rot(input logic [ROT_MAX_W-1:0] x,
                                               input int unsigned         w);
    logic [ROT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
      if (i < w) begin
        if (i == 0) r[i] = x[w-1];
        else        r[i] = x[i-1];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rotation_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)                          count_d = '0;
    else if (inc_i && (count_q != '1))  count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/ring_rotation_monitor.sv
// Checks a circular shift register against its own preset, step by step.
module ring_rotation_monitor
  import ring_monitor_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned REV_WIDTH = 8
) (
  input  logic                       clockpulse,
  input  logic                       clear,
  input  logic                       enablePreset,
  input  logic [WIDTH-1:0]           preset,
  input  logic [WIDTH-1:0]           ringIn,
  output logic                       running,
  output logic                       fault,
  output logic [WIDTH-1:0]           faultPattern,
  output logic [$clog2(WIDTH)-1:0]   stepCount,
  output logic                       revolution,
  output logic [REV_WIDTH-1:0]       revCount,
  output logic                       degenerate
);

  localparam int unsigned SW = $clog2(WIDTH);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [SW-1:0]    step_q, step_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] fpat_q, fpat_d;
  logic             rev_q, rev_d;
  logic             degen_q, degen_d;
  logic             cnt_clr, cnt_inc;
  logic [WIDTH-1:0] rot_next;

  assign rot_next = WIDTH'(rot(ROT_MAX_W'(expected_q), WIDTH));

  // Load takes priority over compare in every state.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    step_d     = step_q;
    fault_d    = fault_q;
    fpat_d     = fpat_q;
    rev_d      = 1'b0;
    degen_d    = degen_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (enablePreset) begin
      state_d    = RUN;
      expected_d = preset;
      step_d     = '0;
      fault_d    = 1'b0;
      fpat_d     = '0;
      degen_d    = (preset == '0) || (preset == '1);
      cnt_clr    = 1'b1;
    end else if (state_q == RUN) begin
      if (ringIn == expected_q) begin
        expected_d = rot_next;
        if (step_q == SW'(WIDTH - 1)) begin
          step_d  = '0;
          rev_d   = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end else begin
        fault_d = 1'b1;
        fpat_d  = ringIn;
        state_d = FAULT;
      end
    end
  end

  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      expected_q <= '0;
      step_q     <= '0;
      fault_q    <= 1'b0;
      fpat_q     <= '0;
      rev_q      <= 1'b0;
      degen_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      step_q     <= step_d;
      fault_q    <= fault_d;
      fpat_q     <= fpat_d;
      rev_q      <= rev_d;
      degen_q    <= degen_d;
    end
  end

  sat_counter #(
    .WIDTH (REV_WIDTH)
  ) u_rev_cnt (
    .clk_i   (clockpulse),
    .rst_ni  (clear),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (revCount)
  );

  assign running      = (state_q == RUN);
  assign fault        = fault_q;
  assign faultPattern = fpat_q;
  assign stepCount    = step_q;
  assign revolution   = rev_q;
  assign degenerate   = degen_q;

endmodule

// File: tb/tb_ring_rotation_monitor.sv
module tb_ring_rotation_monitor;

  localparam int W  = 5;
  localparam int RW = 2;

  logic          clk;
  logic          clear;
  logic          ep;
  logic [W-1:0]  pre;
  logic [W-1:0]  ri;
  logic          running, fault, revolution, degenerate;
  logic [W-1:0]  faultPattern;
  logic [2:0]    stepCount;
  logic [RW-1:0] revCount;

  int passes = 0;
  int total  = 0;

  // reference model: mode 0 idle, 1 run, 2 fault; k = matched steps since load
  int           m_mode;
  logic [W-1:0] m_pat;
  int           m_k;
  logic         m_fault;
  logic [W-1:0] m_fp;
  logic         m_deg;
  logic         m_rev;

  ring_rotation_monitor #(
    .WIDTH     (W),
    .REV_WIDTH (RW)
  ) dut (
    .clockpulse   (clk),
    .clear        (clear),
    .enablePreset (ep),
    .preset       (pre),
    .ringIn       (ri),
    .running      (running),
    .fault        (fault),
    .faultPattern (faultPattern),
    .stepCount    (stepCount),
    .revolution   (revolution),
    .revCount     (revCount),
    .degenerate   (degenerate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pattern rotated left by k positions
  function automatic logic [W-1:0] rotk(input logic [W-1:0] p, input int k);
    logic [2*W-1:0] t;
    t = {p, p} << (k % W);
    return t[2*W-1:W];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pat = '0; m_k = 0; m_fault = 1'b0; m_fp = '0; m_deg = 1'b0; m_rev = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic [W-1:0] p, input logic [W-1:0] r);
    m_rev = 1'b0;
    if (e) begin
      m_mode = 1; m_pat = p; m_k = 0; m_fault = 1'b0; m_fp = '0;
      m_deg = (p == '0) || (p == '1);
    end else if (m_mode == 1) begin
      if (r == rotk(m_pat, m_k)) begin
        m_k++;
        if (m_k % W == 0) m_rev = 1'b1;
      end else begin
        m_fault = 1'b1; m_fp = r; m_mode = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    int rc;
    rc = (m_k / W > 3) ? 3 : m_k / W;
    chk("running",      32'(running),      32'(m_mode == 1));
    chk("fault",        32'(fault),        32'(m_fault));
    chk("faultPattern", 32'(faultPattern), 32'(m_fp));
    chk("stepCount",    32'(stepCount),    32'(m_k % W));
    chk("revolution",   32'(revolution),   32'(m_rev));
    chk("revCount",     32'(revCount),     32'(rc));
    chk("degenerate",   32'(degenerate),   32'(m_deg));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clear) model_edge(ep, pre, ri);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] good();
    return rotk(m_pat, m_k);
  endfunction

  initial begin
    model_reset();
    clear = 1'b0; ep = 1'b0; pre = '0; ri = '0;

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      ep = 1'($urandom); pre = W'($urandom); ri = W'($urandom);
      tick();
    end
    ep = 1'b0;
    #2 clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ri = W'($urandom);
      tick();
    end

    // normal rotation
    ep = 1'b1; pre = 5'b00101; ri = 5'b00101;
    tick();
    ep = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ri = good();
      tick();
    end
    chk("norm_step12", 32'(stepCount), 32'd2);
    chk("norm_rev12",  32'(revCount),  32'd2);

    // injected error on the 4th edge
    ep = 1'b1; pre = 5'b00011; ri = 5'b00011;
    tick();
    ep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ri = good();
      tick();
    end
    ri = 5'b10001;
    tick();
    chk("inj_fp",   32'(faultPattern), 32'h11);
    chk("inj_step", 32'(stepCount),    32'd3);
    for (int i = 0; i < 20; i++) begin
      ri = W'($urandom);
      tick();
    end

    // load beats compare, then clean rotation
    ep = 1'b1; pre = 5'b10000; ri = 5'b01010;
    tick();
    chk("rec_run",   32'(running), 32'd1);
    chk("rec_fault", 32'(fault),   32'd0);
    ep = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ri = good();
      tick();
    end

    // degenerate pattern, revolution counter saturation
    ep = 1'b1; pre = 5'b11111; ri = 5'b11111;
    tick();
    ep = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("deg_flag", 32'(degenerate), 32'd1);
    chk("deg_sat",  32'(revCount),   32'd3);

    // asynchronous clear between edges
    ep = 1'b1; pre = 5'b01101; ri = 5'b01101;
    tick();
    ep = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ri = good();
      tick();
    end
    chk("async_pre_step", 32'(stepCount), 32'd2);
    #2 clear = 1'b0;
    model_reset();
    #1 check_all();
    #1 clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ri = W'($urandom);
      tick();
    end

    // randomized loads, clean rotation and sporadic corruption
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        ep = 1'b1; pre = W'($urandom); ri = W'($urandom);
      end else begin
        ep = 1'b0;
        if ($urandom_range(0, 29) == 0) ri = W'($urandom);
        else                            ri = good();
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ring_rotation_monitor.md
# ring_rotation_monitor

Downstream checker for the 5-bit circular shift register. It samples the register's parallel output on every clock and tracks the pattern the ring must show next from the same preset it was loaded with. It counts shift steps and full revolutions, and latches a fault on the first deviation. It sits beside the ring register, on the same `clockpulse`, `enablePreset` and `preset` nets, with its `ringIn` driven by the register's `out`.

## Interface
Parameters:
- `WIDTH`, default 5: ring length in bits.
- `REV_WIDTH`, default 8: width of the revolution counter.

Ports:
- `clockpulse`, in, 1: single clock; all state changes on the rising edge.
- `clear`, in, 1: reset, asynchronous, active-low.
- `enablePreset`, in, 1: load strobe, shared with the ring register.
- `preset`, in, WIDTH: load pattern, shared with the ring register.
- `ringIn`, in, WIDTH: the ring register's `out` bus.
- `running`, out, 1: monitor is in RUN.
- `fault`, out, 1: sticky mismatch flag.
- `faultPattern`, out, WIDTH: value of `ringIn` captured at the first mismatch.
- `stepCount`, out, $clog2(WIDTH): shift steps since load, modulo WIDTH.
- `revolution`, out, 1: one-cycle pulse on each completed revolution.
- `revCount`, out, REV_WIDTH: completed revolutions since load, saturating.
- `degenerate`, out, 1: loaded pattern is all-0 or all-1, so it is rotation-invariant.

## Operation
- The rotation function is `rot(x)`: `next[0] = x[WIDTH-1]`, and `next[i] = x[i-1]` for i ≥ 1. This matches the ring register's shift direction.
- Internal register `expected` holds the value the ring must show before the current edge.
- States: IDLE, RUN, FAULT.
- **IDLE**, entered from reset: all outputs 0. On `enablePreset`=1 the block does the load and moves to RUN.
- **Load action**, valid in any state:
  - `expected` ← `preset`.
  - `stepCount`, `revCount`, `fault`, `faultPattern` ← 0.
  - `degenerate` ← (`preset` == 0 || `preset` == all-ones).
  - State ← RUN.
- **RUN with `enablePreset`=1**: repeat the load action every cycle. The ring is held at `preset` during this time, so no comparison is made.
- **RUN with `enablePreset`=0 and `ringIn` == `expected`**:
  - `expected` ← `rot(expected)`.
  - `stepCount` ← `stepCount`+1, wrapping from WIDTH-1 to 0.
  - On that wrap, `revolution` = 1 for one cycle and `revCount` increments, saturating at 2^REV_WIDTH-1.
- **RUN with `enablePreset`=0 and `ringIn` ≠ `expected`**:
  - `fault` ← 1 and `faultPattern` ← `ringIn`.
  - State ← FAULT.
  - `stepCount`, `revCount` and `expected` freeze.
- **FAULT**: all outputs hold. The only exits are a load (`enablePreset`=1) or `clear`.
- Load has priority over the compare when both apply on the same edge.
- A degenerate pattern is still checked normally, since any change in `ringIn` is still a fault. `degenerate` is advisory only.

## Timing
- `clear` low: asynchronously forces IDLE. Every output and `expected` go to 0, and `revolution` is deasserted.
- `clear` deasserting mid-run leaves the block in IDLE. It stays there until the next load, with no comparison before that.
- Load latency is one edge: `running` = 1 after the first edge with `enablePreset`=1.
- At the first edge after `enablePreset` falls, the ring still shows `preset`. That edge compares against `preset`, and `stepCount` becomes 1.
- Compare latency: `fault` and `faultPattern` are registered. They assert after the edge that sampled the bad `ringIn`.
- `revolution` is registered and asserts in the cycle after the WIDTH-th consecutive matching edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `ring_monitor_pkg` holds:
  - the state enum (IDLE, RUN, FAULT);
  - the `rot` function, parameterised on width;
  - the `WIDTH` default constant.
- One sub-module, `sat_counter`: REV_WIDTH-bit, synchronous clear, increment enable, holds at all-ones.
- Everything else is a single FSM plus the `expected`, `stepCount` and flag registers.

## Test plan
- **Reset**: hold `clear`=0 with random inputs → all outputs 0 and state IDLE. After release with no load → outputs stay 0 for 10 cycles.
- **Normal rotation**: load `preset`=5'b00101, then drive `ringIn` with the correct rotation sequence 00101, 01010, 10100, 01001, 10010, 00101… for 12 edges → `stepCount` runs 1,2,3,4,0,…; `revolution` pulses after edges 5 and 10; `revCount`=2; `fault`=0.
- **Injected error**: load 5'b00011, then feed the correct rotation for 3 edges, then 5'b11000 on the 4th edge (expected 11000? no: expected 5'b11000 is correct, so inject 5'b10001) → `fault`=1, `faultPattern`=5'b10001, `stepCount`=3 frozen, and all outputs hold for 20 cycles.
- **Recovery and priority**: from FAULT, assert `enablePreset` with `preset`=5'b10000 on the same edge as a mismatching `ringIn` → state RUN, `fault`=0, counters 0. Correct rotation afterwards produces no fault.
- **Degenerate and saturation**: with REV_WIDTH=2, load 5'b11111 and hold `ringIn`=5'b11111 for 25 edges → `degenerate`=1, `revCount` saturates at 3, and `revolution` still pulses every 5 edges.
- **Async reset mid-run**: pull `clear` low between edges at `stepCount`=2 → outputs clear immediately, without waiting for a clock edge, and state is IDLE after release.
